uart_pio_bridge: RTL
====================

UART_PIO_BRIDGE -- requirements
Module: uart_pio_bridge

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk_clk cycles per UART bit (50 MHz / 115200); legal range 8..65535.
REQ-002 clk_clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-003 reset_reset_n  input  1  reset, synchronous and active-low.
REQ-004 uart_rxd  input  1  asynchronous UART receive line, idle high, 8N1.
REQ-005 uart_txd  output  1  UART transmit line, idle high, 8N1.
REQ-006 pio_button_external_connection_export  input  2  asynchronous push buttons, active-low (pressed = 0).
REQ-007 pio_switch_external_connection_export  input  3  asynchronous slide switches.
REQ-008 pio_led_external_connection_export  output  8  LED drive, 1 = lit.
REQ-009 rx_err  output  1  sticky framing-error flag.
REQ-010 tx_busy  output  1  high while a TX frame or pending request exists.

Function
REQ-011 uart_rxd and each button bit SHALL pass through a 2-flop synchronizer; switches SHALL be sampled through a 2-flop synchronizer.
REQ-012 RX FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-013 IDLE -> START on synchronized rxd = 0; counter restarts at 0.
REQ-014 START: at count CLKS_PER_BIT/2 (integer division) rxd = 0 -> DATA; rxd = 1 -> IDLE (glitch rejected, no other effect).
REQ-015 DATA: 8 samples, one every CLKS_PER_BIT cycles after the mid-start point, LSB first, then -> STOP.
REQ-016 STOP: sample after CLKS_PER_BIT cycles; 1 -> LED register <= received byte on that cycle, -> IDLE.
REQ-017 STOP sample 0 -> rx_err <= 1, LED unchanged, -> WAIT_HIGH; WAIT_HIGH -> IDLE on first rxd = 1.
REQ-018 Every valid frame, including 0x00, SHALL overwrite the LED register in full.
REQ-019 Press event = synchronized button bit transitions 1 -> 0; either bit generates one TX request; simultaneous presses generate one request.
REQ-020 Status byte = {3'b101, sw[2:0], ~btn[1:0]}, captured from synchronized inputs on the cycle the frame starts.
REQ-021 TX FSM states: IDLE, START, DATA, STOP; start bit 0, 8 data bits LSB first, stop bit 1, each exactly CLKS_PER_BIT cycles; frame = 10*CLKS_PER_BIT cycles.
REQ-022 uart_txd SHALL go low no later than 4 clk_clk cycles after a button pin falls, when TX idle and no request pending.
REQ-023 Request during an active frame SHALL set a single pending flag; the next frame starts the cycle after STOP ends; further requests while pending is set SHALL be dropped.
REQ-024 tx_busy = (TX state != IDLE) OR pending.
REQ-025 RX and TX SHALL operate independently (full duplex); a simultaneous RX completion and TX request SHALL both take effect.
REQ-026 Bit counters SHALL be 3 bits, baud counters 16 bits; no counter overflow at CLKS_PER_BIT = 65535.
REQ-027 uart_txd SHALL be driven from a register (glitch-free).

Reset
REQ-028 While reset_reset_n = 0 at a clock edge: both FSMs -> IDLE, uart_txd = 1, LED = 0x00, rx_err = 0, tx_busy = 0, pending = 0, counters = 0, synchronizers = 1 (buttons and rxd), switch synchronizers = 0.
REQ-029 Reset mid-frame SHALL abort the frame: uart_txd = 1 on the first edge after reset is sampled low; partially received byte discarded, LED = 0x00.
REQ-030 No press event SHALL be generated by the first cycles after reset if buttons are held released.
REQ-031 rx_err SHALL clear only by reset.

Verification (CLKS_PER_BIT = 16)
REQ-032 Send 0xA5 valid 8N1 on uart_rxd -> LED = 0xA5 after stop-bit sample, rx_err = 0.
REQ-033 Send 0x3C with stop bit 0 -> rx_err = 1, LED keeps previous value; then valid 0x0F -> LED = 0x0F, rx_err stays 1.
REQ-034 rxd low pulse 5 cycles -> no LED change, no rx_err.
REQ-035 sw = 3'b110, press button[0] -> uart_txd carries 0xB9 (start 0, bits 1,0,0,1,1,1,0,1, stop 1), 160 cycles, tx_busy high throughout.
REQ-036 Press button[1] twice during a frame -> exactly one additional frame, back-to-back, then tx_busy = 0.
REQ-037 Assert reset at cycle 70 of a TX frame -> uart_txd = 1 next edge, LED = 0x00, tx_busy = 0.

Source files
------------

// File: rtl/uart_pio_bridge.sv
// uart_pio_bridge
//   Bridges a UART link (8N1) to a small set of parallel I/O.
//   - Every valid received byte is written to the LED register.
//   - Every push-button press sends one status byte over UART TX:
//     {3'b101, switches[2:0], pressed buttons[1:0]}.
//
// Ports
//   clk_clk                                 system clock, rising edge
//   reset_reset_n                           synchronous active-low reset
//   uart_rxd                                UART receive line (async, idle high)
//   uart_txd                                UART transmit line (registered, idle high)
//   pio_button_external_connection_export   push buttons, active-low (async)
//   pio_switch_external_connection_export   slide switches (async)
//   pio_led_external_connection_export      LED register, 1 = lit
//   rx_err                                  sticky framing-error flag
//   tx_busy                                 TX frame in progress or request pending
//
// RX FSM
//   state        | meaning
//   RX_IDLE      | line idle, waiting for a falling edge
//   RX_START     | counting to mid start bit, confirm it is still low
//   RX_DATA      | sampling 8 data bits, LSB first, one per bit period
//   RX_STOP      | sampling stop bit; high commits byte to LEDs
//   RX_WAIT_HIGH | framing error seen, wait for line to return high
//
// TX FSM
//   state        | meaning
//   TX_IDLE      | line idle, waiting for a request
//   TX_START     | driving start bit (0)
//   TX_DATA      | driving 8 data bits, LSB first
//   TX_STOP      | driving stop bit (1); may chain straight into next frame

module uart_pio_bridge #(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       clk_clk,
   input  logic       reset_reset_n,
   input  logic       uart_rxd,
   output logic       uart_txd,
   input  logic [1:0] pio_button_external_connection_export,
   input  logic [2:0] pio_switch_external_connection_export,
   output logic [7:0] pio_led_external_connection_export,
   output logic       rx_err,
   output logic       tx_busy
);

   localparam logic [2:0] RX_IDLE      = 3'd0;
   localparam logic [2:0] RX_START     = 3'd1;
   localparam logic [2:0] RX_DATA      = 3'd2;
   localparam logic [2:0] RX_STOP      = 3'd3;
   localparam logic [2:0] RX_WAIT_HIGH = 3'd4;

   localparam logic [1:0] TX_IDLE  = 2'd0;
   localparam logic [1:0] TX_START = 2'd1;
   localparam logic [1:0] TX_DATA  = 2'd2;
   localparam logic [1:0] TX_STOP  = 2'd3;

   // Baud timers are down-counters; terminal count is zero.
   // A full bit lasts BIT_TC+1 cycles; the start-bit check lasts HALF_TC+1.
   localparam logic [15:0] BIT_TC  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_TC = 16'(CLKS_PER_BIT / 2);

   // ------------------------------------------------------------------
   // Input synchronizers
   // ------------------------------------------------------------------
   logic       rxd_meta, rxd_sync;
   logic [1:0] btn_meta, btn_sync, btn_prev;
   logic [2:0] sw_meta, sw_sync;
   logic       press;

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         rxd_meta <= 1'b1;
         rxd_sync <= 1'b1;
         btn_meta <= 2'b11;
         btn_sync <= 2'b11;
         btn_prev <= 2'b11;
         sw_meta  <= 3'b000;
         sw_sync  <= 3'b000;
      end else begin
         rxd_meta <= uart_rxd;
         rxd_sync <= rxd_meta;
         btn_meta <= pio_button_external_connection_export;
         btn_sync <= btn_meta;
         btn_prev <= btn_sync;
         sw_meta  <= pio_switch_external_connection_export;
         sw_sync  <= sw_meta;
      end
   end

   // Any 1->0 transition on either button is one request; simultaneous
   // presses fold into a single request.
   assign press = |(btn_prev & ~btn_sync);

   // ------------------------------------------------------------------
   // Receiver
   // ------------------------------------------------------------------
   logic [2:0]  rx_state;
   logic [15:0] rx_cnt;
   logic [2:0]  rx_bit;
   logic [7:0]  rx_shreg;
   logic [7:0]  led_reg;
   logic        rx_err_reg;

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         rx_state   <= RX_IDLE;
         rx_cnt     <= 16'd0;
         rx_bit     <= 3'd0;
         rx_shreg   <= 8'h00;
         led_reg    <= 8'h00;
         rx_err_reg <= 1'b0;
      end else begin
         case (rx_state)
            RX_IDLE: begin
               if (!rxd_sync) begin
                  rx_state <= RX_START;
                  rx_cnt   <= HALF_TC;
               end
            end
            RX_START: begin
               if (rx_cnt == 16'd0) begin
                  if (!rxd_sync) begin
                     rx_state <= RX_DATA;
                     rx_cnt   <= BIT_TC;
                     rx_bit   <= 3'd0;
                  end else begin
                     rx_state <= RX_IDLE;
                  end
               end else begin
                  rx_cnt <= rx_cnt - 16'd1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == 16'd0) begin
                  rx_shreg <= {rxd_sync, rx_shreg[7:1]};
                  rx_cnt   <= BIT_TC;
                  if (rx_bit == 3'd7) begin
                     rx_state <= RX_STOP;
                  end else begin
                     rx_bit <= rx_bit + 3'd1;
                  end
               end else begin
                  rx_cnt <= rx_cnt - 16'd1;
               end
            end
            RX_STOP: begin
               if (rx_cnt == 16'd0) begin
                  if (rxd_sync) begin
                     led_reg  <= rx_shreg;
                     rx_state <= RX_IDLE;
                  end else begin
                     rx_err_reg <= 1'b1;
                     rx_state   <= RX_WAIT_HIGH;
                  end
               end else begin
                  rx_cnt <= rx_cnt - 16'd1;
               end
            end
            RX_WAIT_HIGH: begin
               if (rxd_sync) begin
                  rx_state <= RX_IDLE;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   assign pio_led_external_connection_export = led_reg;
   assign rx_err                             = rx_err_reg;

   // ------------------------------------------------------------------
   // Transmitter
   // ------------------------------------------------------------------
   logic [1:0]  tx_state;
   logic [15:0] tx_cnt;
   logic [2:0]  tx_bit;
   logic [7:0]  tx_shreg;
   logic        tx_pend;
   logic        txd_reg;
   logic        tx_want;
   logic        tx_start;
   logic [7:0]  status_byte;

   assign status_byte = {3'b101, sw_sync, ~btn_sync};
   assign tx_want     = press | tx_pend;

   // A new frame begins from idle, or directly at the end of a stop bit so
   // that queued frames go out back-to-back with no idle gap.
   assign tx_start = tx_want &
                     ((tx_state == TX_IDLE) |
                      ((tx_state == TX_STOP) & (tx_cnt == 16'd0)));

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= 16'd0;
         tx_bit   <= 3'd0;
         tx_shreg <= 8'h00;
         tx_pend  <= 1'b0;
         txd_reg  <= 1'b1;
      end else begin
         if (tx_start) begin
            tx_state <= TX_START;
            tx_cnt   <= BIT_TC;
            tx_shreg <= status_byte;
            txd_reg  <= 1'b0;
         end else begin
            case (tx_state)
               TX_START: begin
                  if (tx_cnt == 16'd0) begin
                     txd_reg  <= tx_shreg[0];
                     tx_shreg <= {1'b0, tx_shreg[7:1]};
                     tx_bit   <= 3'd0;
                     tx_cnt   <= BIT_TC;
                     tx_state <= TX_DATA;
                  end else begin
                     tx_cnt <= tx_cnt - 16'd1;
                  end
               end
               TX_DATA: begin
                  if (tx_cnt == 16'd0) begin
                     tx_cnt <= BIT_TC;
                     if (tx_bit == 3'd7) begin
                        txd_reg  <= 1'b1;
                        tx_state <= TX_STOP;
                     end else begin
                        txd_reg  <= tx_shreg[0];
                        tx_shreg <= {1'b0, tx_shreg[7:1]};
                        tx_bit   <= tx_bit + 3'd1;
                     end
                  end else begin
                     tx_cnt <= tx_cnt - 16'd1;
                  end
               end
               TX_STOP: begin
                  if (tx_cnt == 16'd0) begin
                     tx_state <= TX_IDLE;
                  end else begin
                     tx_cnt <= tx_cnt - 16'd1;
                  end
               end
               default: begin
                  tx_state <= TX_IDLE;
                  txd_reg  <= 1'b1;
               end
            endcase
         end

         // Single-entry queue: a frame start consumes it, a press during an
         // active frame fills it, and further presses are absorbed.
         if (tx_start) begin
            tx_pend <= 1'b0;
         end else if (press && (tx_state != TX_IDLE)) begin
            tx_pend <= 1'b1;
         end
      end
   end

   assign uart_txd = txd_reg;
   assign tx_busy  = (tx_state != TX_IDLE) | tx_pend;

endmodule
